rf16_wr_sched: RTL and testbench



---
 rtl/rf16_wr_sched.sv | 160 ++++++++++++++++
 tb/tb_rf16_wr_sched.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf16_wr_sched.sv
// rf16_wr_sched: write-port scheduler for the 16-entry queue register file.
//
// Shares the register file's single write port between two producers with
// round-robin valid/ready arbitration. After reset, or on a clr_req pulse, it
// runs a 16-cycle zero-fill sweep of every entry. All register-file strobes
// are driven from registers.
//
// Optional feature: define RF16_WR_LOCK_EN to add a per-entry write-lock
// bitmap. Writes to locked entries are dropped and flagged on wr_err. The
// clear sweep also skips locked entries.
//
// Ports:
//   clk                     clock
//   reset_l                 synchronous reset, active-low
//   clr_req                 pulse: start a zero-fill sweep (ignored mid-sweep)
//   clr_busy                high while the sweep is running
//   reqN_valid/ready        producer N handshake (N = 0, 1)
//   reqN_addr/data          producer N target entry and write data
//   rf_wen                  register-file write enable
//   rf_word_wen             register-file word enable (WORD_SEL on writes)
//   rf_wr_addr/rf_wr_data   register-file write address / data
//   last_grant              id of the most recently granted producer
//   lock_wen/lock_addr      (RF16_WR_LOCK_EN) set the lock bit of an entry
//   wr_err                  (RF16_WR_LOCK_EN) one-cycle pulse: locked write dropped
module rf16_wr_sched #(
    parameter int         DW       = 8,
    parameter logic [3:0] WORD_SEL = 4'b0100
) (
    input  logic          clk,
    input  logic          reset_l,
    input  logic          clr_req,
    output logic          clr_busy,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [3:0]    req0_addr,
    input  logic [DW-1:0] req0_data,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [3:0]    req1_addr,
    input  logic [DW-1:0] req1_data,
    output logic          rf_wen,
    output logic [3:0]    rf_word_wen,
    output logic [3:0]    rf_wr_addr,
    output logic [DW-1:0] rf_wr_data,
    output logic          last_grant
`ifdef RF16_WR_LOCK_EN
    ,
    input  logic          lock_wen,
    input  logic [3:0]    lock_addr,
    output logic          wr_err
`endif
);

    typedef enum logic {
        CLEAR = 1'b0,
        ARB   = 1'b1
    } state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic          arb_ok;
    logic          grant0;
    logic          grant1;
    logic          hs;
    logic [3:0]    hs_addr;
    logic [DW-1:0] hs_data;
    logic          hs_locked;
    logic          slot_locked;

`ifdef RF16_WR_LOCK_EN
    logic [15:0]   lock_map;

    // Lock checks use the bitmap as it stood before this edge, so a lock set
    // in the same cycle as a write to that entry does not block the write.
    assign hs_locked   = lock_map[hs_addr];
    assign slot_locked = lock_map[cnt];
`else
    assign hs_locked   = 1'b0;
    assign slot_locked = 1'b0;
`endif

    // Readies are combinational. A clr_req in ARB takes precedence over any
    // request. Readies are also held low under reset so no handshake can
    // appear to complete on a reset edge.
    always_comb begin
        arb_ok = reset_l && (state == ARB) && !clr_req;
        grant0 = arb_ok && req0_valid && (!req1_valid || last_grant);
        grant1 = arb_ok && req1_valid && (!req0_valid || !last_grant);
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign hs         = grant0 || grant1;
    assign hs_addr    = grant1 ? req1_addr : req0_addr;
    assign hs_data    = grant1 ? req1_data : req0_data;

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state       <= CLEAR;
            cnt         <= 4'd0;
            clr_busy    <= 1'b0;
            rf_wen      <= 1'b0;
            rf_word_wen <= 4'd0;
            rf_wr_addr  <= 4'd0;
            rf_wr_data  <= '0;
            last_grant  <= 1'b1;
`ifdef RF16_WR_LOCK_EN
            wr_err      <= 1'b0;
            lock_map    <= 16'd0;
`endif
        end else begin
            // Strobes default low; addr/data hold unless a write is issued.
            rf_wen      <= 1'b0;
            rf_word_wen <= 4'd0;
`ifdef RF16_WR_LOCK_EN
            wr_err      <= 1'b0;
            if (lock_wen) begin
                lock_map[lock_addr] <= 1'b1;
            end
`endif
            case (state)
                CLEAR: begin
                    // A locked slot still uses its cycle, so the sweep is
                    // always exactly 16 cycles long.
                    rf_wen      <= !slot_locked;
                    rf_word_wen <= slot_locked ? 4'd0 : WORD_SEL;
                    rf_wr_addr  <= cnt;
                    rf_wr_data  <= '0;
                    cnt         <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        state    <= ARB;
                        clr_busy <= 1'b0;
                    end else begin
                        clr_busy <= 1'b1;
                    end
                end
                ARB: begin
                    if (clr_req) begin
                        state    <= CLEAR;
                        cnt      <= 4'd0;
                        clr_busy <= 1'b1;
                    end else if (hs) begin
                        rf_wr_addr  <= hs_addr;
                        rf_wr_data  <= hs_data;
                        rf_wen      <= !hs_locked;
                        rf_word_wen <= hs_locked ? 4'd0 : WORD_SEL;
                        last_grant  <= grant1;
`ifdef RF16_WR_LOCK_EN
                        wr_err      <= hs_locked;
`endif
                    end
                end
                default: begin
                    state <= CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf16_wr_sched.sv
// Self-checking bench for rf16_wr_sched: a cycle model written from the
// behaviour rules runs next to the DUT, plus directed scenarios with literal
// expectations.
module tb_rf16_wr_sched;

    localparam int         DW       = 8;
    localparam logic [3:0] WORD_SEL = 4'b0100;

    logic          clk;
    logic          reset_l;
    logic          clr_req;
    logic          clr_busy;
    logic          req0_valid, req0_ready;
    logic [3:0]    req0_addr;
    logic [DW-1:0] req0_data;
    logic          req1_valid, req1_ready;
    logic [3:0]    req1_addr;
    logic [DW-1:0] req1_data;
    logic          rf_wen;
    logic [3:0]    rf_word_wen;
    logic [3:0]    rf_wr_addr;
    logic [DW-1:0] rf_wr_data;
    logic          last_grant;
`ifdef RF16_WR_LOCK_EN
    logic          lock_wen;
    logic [3:0]    lock_addr;
    logic          wr_err;
`endif

    rf16_wr_sched #(.DW(DW), .WORD_SEL(WORD_SEL)) dut (
        .clk        (clk),
        .reset_l    (reset_l),
        .clr_req    (clr_req),
        .clr_busy   (clr_busy),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .rf_wen     (rf_wen),
        .rf_word_wen(rf_word_wen),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_data (rf_wr_data),
        .last_grant (last_grant)
`ifdef RF16_WR_LOCK_EN
        ,
        .lock_wen   (lock_wen),
        .lock_addr  (lock_addr),
        .wr_err     (wr_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: remaining sweep slots, last winner, lock set, and the
    // output values expected after the next clock edge.
    // ------------------------------------------------------------------
    bit            m_known = 0;
    int            m_sweep_left;
    bit            m_last;
    bit            m_lock [16];
    logic          m_wen, m_busy, m_err;
    logic [3:0]    m_wwen, m_addr;
    logic [DW-1:0] m_data;
    logic          m_e0, m_e1;

    initial begin
        int slot;
        bit locked;
        forever begin
            @(negedge clk);
            if (m_known) begin
                chk("mdl_rf_wen",      rf_wen,      m_wen);
                chk("mdl_rf_word_wen", rf_word_wen, m_wwen);
                chk("mdl_rf_wr_addr",  rf_wr_addr,  m_addr);
                chk("mdl_rf_wr_data",  rf_wr_data,  m_data);
                chk("mdl_last_grant",  last_grant,  m_last);
                chk("mdl_clr_busy",    clr_busy,    m_busy);
`ifdef RF16_WR_LOCK_EN
                chk("mdl_wr_err",      wr_err,      m_err);
`endif
            end
            m_e0 = 1'b0;
            m_e1 = 1'b0;
            if (m_known && reset_l && m_sweep_left == 0 && !clr_req) begin
                if (req0_valid && req1_valid) begin
                    // Alternate: whoever did not win last time.
                    if (m_last) m_e0 = 1'b1;
                    else        m_e1 = 1'b1;
                end else begin
                    m_e0 = req0_valid;
                    m_e1 = req1_valid;
                end
            end
            if (m_known) begin
                chk("mdl_req0_ready", req0_ready, m_e0);
                chk("mdl_req1_ready", req1_ready, m_e1);
            end
            if (!reset_l) begin
                m_known = 1;
                m_sweep_left = 16;
                m_last = 1;
                m_wen = 0; m_wwen = 0; m_addr = 0; m_data = 0;
                m_busy = 0; m_err = 0;
                for (int i = 0; i < 16; i++) m_lock[i] = 0;
            end else if (m_known) begin
                m_wen = 0; m_wwen = 0; m_err = 0;
                if (m_sweep_left > 0) begin
                    slot = 16 - m_sweep_left;
                    m_addr = slot[3:0];
                    m_data = 0;
                    m_wen  = !m_lock[slot];
                    m_wwen = m_wen ? WORD_SEL : 4'd0;
                    m_sweep_left--;
                    m_busy = (m_sweep_left > 0);
                end else if (clr_req) begin
                    m_sweep_left = 16;
                    m_busy = 1;
                end else if (m_e0 || m_e1) begin
                    m_addr = m_e1 ? req1_addr : req0_addr;
                    m_data = m_e1 ? req1_data : req0_data;
                    m_last = m_e1;
                    locked = m_lock[m_addr];
                    m_wen  = !locked;
                    m_wwen = locked ? 4'd0 : WORD_SEL;
                    m_err  = locked;
                    m_busy = 0;
                end else begin
                    m_busy = 0;
                end
`ifdef RF16_WR_LOCK_EN
                if (lock_wen) m_lock[lock_addr] = 1;
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit         p;
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    initial begin
        wr_t tbl [4];
        int  n;
        tbl[0] = '{0, 4'hF, 8'hFF};
        tbl[1] = '{1, 4'h0, 8'h00};
        tbl[2] = '{1, 4'h7, 8'h3C};
        tbl[3] = '{0, 4'h8, 8'hC3};

        reset_l = 0; clr_req = 0;
        req0_valid = 0; req0_addr = 0; req0_data = 0;
        req1_valid = 0; req1_addr = 0; req1_data = 0;
`ifdef RF16_WR_LOCK_EN
        lock_wen = 0; lock_addr = 0;
`endif

        // Reset held for three edges, then the power-on sweep.
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_rf_wen", rf_wen, 1'b0);
        chk("rst_rf_wr_addr", rf_wr_addr, 4'd0);
        chk("rst_last_grant", last_grant, 1'b1);
        @(posedge clk);
        #1 reset_l = 1;
        for (int i = 0; i < 16; i++) begin
            tick;
            @(negedge clk);
            chk("sweep_wen", rf_wen, 1'b1);
            chk("sweep_addr", rf_wr_addr, i);
            chk("sweep_data", rf_wr_data, 8'h00);
            chk("sweep_busy", clr_busy, (i < 15) ? 1'b1 : 1'b0);
        end

        // Single producer write.
        tick;
        req0_valid = 1; req0_addr = 4'd5; req0_data = 8'hA3;
        @(negedge clk);
        chk("single_ready", req0_ready, 1'b1);
        tick;
        req0_valid = 0;
        @(negedge clk);
        chk("single_wen", rf_wen, 1'b1);
        chk("single_addr", rf_wr_addr, 4'd5);
        chk("single_data", rf_wr_data, 8'hA3);
        chk("single_wwen", rf_word_wen, 4'b0100);
        chk("single_grant", last_grant, 1'b0);

        // Contention from reset: both producers always valid.
        tick;
        reset_l = 0;
        req0_valid = 1; req0_addr = 4'd1; req0_data = 8'd11;
        req1_valid = 1; req1_addr = 4'd2; req1_data = 8'd22;
        repeat (3) tick;
        reset_l = 1;
        @(negedge clk);
        n = 0;
        while (n < 40 && !(req0_ready || req1_ready)) begin
            tick;
            @(negedge clk);
            n++;
        end
        chk("cont_start_bound", (n < 40), 1'b1);
        for (int j = 0; j < 4; j++) begin
            chk("cont_ready0", req0_ready, (j % 2 == 0));
            chk("cont_ready1", req1_ready, (j % 2 == 1));
            tick;
            if (j == 3) begin
                req0_valid = 0;
                req1_valid = 0;
            end
            @(negedge clk);
            chk("cont_addr", rf_wr_addr, (j % 2 == 0) ? 4'd1 : 4'd2);
            chk("cont_data", rf_wr_data, (j % 2 == 0) ? 8'd11 : 8'd22);
            chk("cont_wen", rf_wen, 1'b1);
        end

        // clr_req collides with a producer-1 request.
        tick;
        req1_valid = 1; req1_addr = 4'd9; req1_data = 8'h5A;
        clr_req = 1;
        @(negedge clk);
        chk("clr_blocks_ready", req1_ready, 1'b0);
        tick;
        clr_req = 0;
        @(negedge clk);
        chk("clr_first_wen", rf_wen, 1'b0);
        chk("clr_first_busy", clr_busy, 1'b1);
        for (int k = 0; k < 16; k++) begin
            tick;
            clr_req = (k == 5);
            @(negedge clk);
            chk("clr_sweep_addr", rf_wr_addr, k);
            chk("clr_sweep_wen", rf_wen, 1'b1);
            chk("clr_sweep_ready", req1_ready, (k == 15));
        end
        tick;
        req1_valid = 0;
        @(negedge clk);
        chk("clr_after_addr", rf_wr_addr, 4'd9);
        chk("clr_after_data", rf_wr_data, 8'h5A);
        chk("clr_after_grant", last_grant, 1'b1);

        // Reset in the middle of a sweep.
        tick;
        clr_req = 1;
        tick;
        clr_req = 0;
        for (int k = 0; k < 8; k++) begin
            tick;
            if (k == 7) reset_l = 0;
            @(negedge clk);
            chk("mid_sweep_addr", rf_wr_addr, k);
        end
        tick;
        reset_l = 1;
        @(negedge clk);
        chk("mid_rst_wen", rf_wen, 1'b0);
        chk("mid_rst_wwen", rf_word_wen, 4'd0);
        chk("mid_rst_addr", rf_wr_addr, 4'd0);
        chk("mid_rst_data", rf_wr_data, 8'd0);
        chk("mid_rst_busy", clr_busy, 1'b0);
        chk("mid_rst_grant", last_grant, 1'b1);
        tick;
        @(negedge clk);
        chk("restart_wen", rf_wen, 1'b1);
        chk("restart_addr", rf_wr_addr, 4'd0);
        chk("restart_busy", clr_busy, 1'b1);
        repeat (16) tick;

        // Boundary addresses/data, with an idle cycle showing addr/data hold.
        foreach (tbl[t]) begin
            tick;
            if (tbl[t].p) begin
                req1_valid = 1; req1_addr = tbl[t].a; req1_data = tbl[t].d;
            end else begin
                req0_valid = 1; req0_addr = tbl[t].a; req0_data = tbl[t].d;
            end
            tick;
            req0_valid = 0;
            req1_valid = 0;
            @(negedge clk);
            chk("tbl_addr", rf_wr_addr, tbl[t].a);
            chk("tbl_data", rf_wr_data, tbl[t].d);
            chk("tbl_grant", last_grant, tbl[t].p);
            tick;
            @(negedge clk);
            chk("hold_wen", rf_wen, 1'b0);
            chk("hold_addr", rf_wr_addr, tbl[t].a);
            chk("hold_data", rf_wr_data, tbl[t].d);
        end

`ifdef RF16_WR_LOCK_EN
        // Lock entry 3, write it, then sweep past it.
        tick;
        lock_wen = 1; lock_addr = 4'd3;
        tick;
        lock_wen = 0;
        req0_valid = 1; req0_addr = 4'd3; req0_data = 8'h77;
        @(negedge clk);
        chk("lock_ready", req0_ready, 1'b1);
        tick;
        req0_valid = 0;
        @(negedge clk);
        chk("lock_wen_blocked", rf_wen, 1'b0);
        chk("lock_err", wr_err, 1'b1);
        tick;
        @(negedge clk);
        chk("lock_err_clear", wr_err, 1'b0);
        tick;
        clr_req = 1;
        tick;
        clr_req = 0;
        for (int k = 0; k < 16; k++) begin
            tick;
            @(negedge clk);
            chk("lock_sweep_wen", rf_wen, (k != 3));
        end
        tick;
`endif

        tick;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
